regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (regWrite/rd/writeData) between two write-back sources.
  - Source A: ALU result path.
  - Source B: load/memory return path.
- Round-robin arbitration with per-source valid/ready handshake.
- Drops writes to x0 and to out-of-range registers.
- Drives a registered write stage straight into Register_File, and counts write-back conflicts for performance monitoring.

Parameters:
- DATA_W, 64, width of write-back data.
- ADDR_W, 5, width of register index.
- NUM_REGS, 18, number of implemented registers; rd >= NUM_REGS is out of range.
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- a_valid  input  1  source A has a write-back pending.
- a_rd  input  ADDR_W  source A destination register.
- a_data  input  DATA_W  source A write data.
- a_ready  output  1  source A request consumed this cycle (combinational).
- b_valid  input  1  source B has a write-back pending.
- b_rd  input  ADDR_W  source B destination register.
- b_data  input  DATA_W  source B write data.
- b_ready  output  1  source B request consumed this cycle (combinational).
- regWrite  output  1  write enable to register file (registered).
- rd  output  ADDR_W  write index to register file (registered).
- writeData  output  DATA_W  write data to register file (registered).
- drop_err  output  1  one-cycle pulse: an out-of-range rd was consumed and discarded (registered).
- conflict_cnt  output  CNT_W  count of cycles where A and B both presented writable requests.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - regWrite=0, rd=0, writeData=0, drop_err=0, conflict_cnt=0.
  - last_grant=B, so A wins the first contention.
- While reset is high, a_ready=b_ready=0.
- Request classification, per source each cycle:
  - writable: valid && rd!=0 && rd<NUM_REGS.
  - null: valid && rd==0.
  - bad: valid && rd>=NUM_REGS.
- Null and bad requests never use the write slot. Their ready is 1 in the same cycle, independent of the other source.
- Arbitration among writable requests:
  - Only one writable: it is granted, ready=1.
  - Both writable: the source not in last_grant wins. The loser's ready=0; it must hold valid/rd/data stable until ready. conflict_cnt increments, saturating at all-ones.
- last_grant updates to the winner on every writable grant. It is unchanged in cycles with no writable grant.
- A source with valid=0 has ready=0.
- Latency: a handshake in cycle N produces regWrite=1, rd, writeData in cycle N+1. The register file commits at the rising edge ending cycle N+1.
- No writable grant in cycle N gives regWrite=0 in N+1. rd/writeData hold their previous values.
- drop_err=1 in cycle N+1 if any bad request was consumed in cycle N (A, B or both); otherwise 0.
- Throughput:
  - Maximum one register write per cycle.
  - Under continuous contention, grants alternate A,B,A,B. Worst-case wait for any source is 1 cycle.
- Same rd from A and B in one cycle: both writes are performed in grant order, and the later grant's data is the final register value. Program ordering across sources is the issuing pipeline's responsibility.
- Reset asserted mid-operation:
  - Any request not yet registered is lost.
  - The output stage clears to regWrite=0 immediately (asynchronous).
  - Sources re-present after reset.
- No internal storage beyond the single output stage and last_grant. There is no buffering and no full/empty state; backpressure is via ready only.

Test Plan:
- Reset then single write: A valid, rd=5, data=0x1234 -> a_ready=1 in cycle N; regWrite=1, rd=5, writeData=0x1234 in N+1; regWrite=0 in N+2.
- First contention: A(rd=3, data=0xA), B(rd=4, data=0xB) both valid from reset -> A granted first, B second; outputs (3,0xA) then (4,0xB) on consecutive cycles; conflict_cnt=1.
- Sustained contention: A and B both held valid for 6 cycles, re-presenting after each grant -> grants alternate A,B,A,B,A,B; conflict_cnt advances every cycle.
- x0 and out-of-range drops:
  - A rd=0 with B rd=7 -> both ready same cycle; only rd=7 written; drop_err=0.
  - A rd=20 -> a_ready=1; regWrite=0 and drop_err=1 next cycle.
- Same-destination collision: A(rd=9, 0x11), B(rd=9, 0x22) with last_grant=A -> B written first, then A; final register 9 value 0x11.
- Asynchronous reset pulse mid-cycle while regWrite=1 -> regWrite, rd, writeData and conflict_cnt drop to 0 before the next clock edge; the next contention grants A first.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter sharing the register-file write port between ALU and load write-back
module regfile_wb_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 18,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              regWrite,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] writeData,
    output logic              drop_err,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] LP_NUM_REGS = (ADDR_W + 1)'(NUM_REGS);

    grant_e              r_last_grant;
    grant_e              w_last_grant_nxt;

    logic                r_reg_write;
    logic [ADDR_W-1:0]   r_rd;
    logic [DATA_W-1:0]   r_write_data;
    logic                r_drop_err;
    logic [CNT_W-1:0]    r_conflict_cnt;

    logic                w_a_zero;
    logic                w_a_in_range;
    logic                w_a_wr;
    logic                w_a_bad;
    logic                w_a_drop;
    logic                w_b_zero;
    logic                w_b_in_range;
    logic                w_b_wr;
    logic                w_b_bad;
    logic                w_b_drop;
    logic                w_both_wr;
    logic                w_grant_a;
    logic                w_grant_b;
    logic                w_grant_any;
    logic [ADDR_W-1:0]   w_wr_rd;
    logic [DATA_W-1:0]   w_wr_data;

    assign w_a_zero     = (a_rd == '0);
    assign w_a_in_range = ({1'b0, a_rd} < LP_NUM_REGS);
    assign w_a_wr       = a_valid && !w_a_zero && w_a_in_range;
    assign w_a_bad      = a_valid && !w_a_in_range;
    assign w_a_drop     = a_valid && (w_a_zero || !w_a_in_range);

    assign w_b_zero     = (b_rd == '0);
    assign w_b_in_range = ({1'b0, b_rd} < LP_NUM_REGS);
    assign w_b_wr       = b_valid && !w_b_zero && w_b_in_range;
    assign w_b_bad      = b_valid && !w_b_in_range;
    assign w_b_drop     = b_valid && (w_b_zero || !w_b_in_range);

    // Under contention the source that did not win last time goes first.
    assign w_both_wr    = w_a_wr && w_b_wr;
    assign w_grant_a    = w_a_wr && (!w_b_wr || (r_last_grant == GRANT_B));
    assign w_grant_b    = w_b_wr && (!w_a_wr || (r_last_grant == GRANT_A));
    assign w_grant_any  = w_grant_a || w_grant_b;

    assign w_wr_rd      = w_grant_a ? a_rd   : b_rd;
    assign w_wr_data    = w_grant_a ? a_data : b_data;

    assign a_ready      = !reset && (w_a_drop || w_grant_a);
    assign b_ready      = !reset && (w_b_drop || w_grant_b);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= GRANT_B;
        end else begin
            r_last_grant <= w_last_grant_nxt;
        end
    end

    always_comb begin
        w_last_grant_nxt = r_last_grant;
        if (w_grant_a) begin
            w_last_grant_nxt = GRANT_A;
        end else if (w_grant_b) begin
            w_last_grant_nxt = GRANT_B;
        end
    end

    // rd/writeData keep their last value when no write is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg_write  <= 1'b0;
            r_rd         <= '0;
            r_write_data <= '0;
            r_drop_err   <= 1'b0;
        end else begin
            r_reg_write <= w_grant_any;
            r_drop_err  <= w_a_bad || w_b_bad;
            if (w_grant_any) begin
                r_rd         <= w_wr_rd;
                r_write_data <= w_wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_conflict_cnt <= '0;
        end else if (w_both_wr && (r_conflict_cnt != '1)) begin
            r_conflict_cnt <= r_conflict_cnt + 1'b1;
        end
    end

    assign regWrite     = r_reg_write;
    assign rd           = r_rd;
    assign writeData    = r_write_data;
    assign drop_err     = r_drop_err;
    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0;
    logic [4:0]  a_rd = '0;
    logic [63:0] a_data = '0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [4:0]  b_rd = '0;
    logic [63:0] b_data = '0;
    logic        b_ready;
    logic        regWrite;
    logic [4:0]  rd;
    logic [63:0] writeData;
    logic        drop_err;
    logic [15:0] conflict_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] shadow [32];

    regfile_wb_arbiter #(
        .DATA_W(64), .ADDR_W(5), .NUM_REGS(18), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .regWrite(regWrite), .rd(rd), .writeData(writeData),
        .drop_err(drop_err), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (regWrite) shadow[rd] <= writeData;
    end

    task automatic drive(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                         input logic bv, input logic [4:0] brd, input logic [63:0] bd);
        a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1, 5, 64'h1, 1, 6, 64'h2);
        #1;
        n_vec++;
        if ({a_ready, b_ready} !== 2'b00) begin
            n_err++; $display("FAIL reset_ready: got %b want 00", {a_ready, b_ready});
        end
        n_vec++;
        if ({regWrite, rd, writeData, drop_err, conflict_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got rw=%b rd=%0d wd=%h de=%b cnt=%0d want all 0",
                     regWrite, rd, writeData, drop_err, conflict_cnt);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        drive(1, 5, 64'h1234, 0, 0, 0);
        #1;
        n_vec++;
        if ({a_ready, b_ready} !== 2'b10) begin
            n_err++; $display("FAIL single_ready: got %b want 10", {a_ready, b_ready});
        end
        @(posedge clk); #1;
        n_vec++;
        if (regWrite !== 1'b1 || rd !== 5'd5 || writeData !== 64'h1234) begin
            n_err++; $display("FAIL single_write: got rw=%b rd=%0d wd=%h want 1 5 1234", regWrite, rd, writeData);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        n_vec++;
        if (regWrite !== 1'b0 || rd !== 5'd5 || writeData !== 64'h1234) begin
            n_err++; $display("FAIL single_idle: got rw=%b rd=%0d wd=%h want 0 5 1234", regWrite, rd, writeData);
        end
    endtask

    task automatic test_first_contention();
        do_reset();
        @(negedge clk);
        drive(1, 3, 64'hA, 1, 4, 64'hB);
        #1;
        n_vec++;
        if ({a_ready, b_ready} !== 2'b10) begin
            n_err++; $display("FAIL first_ready0: got %b want 10", {a_ready, b_ready});
        end
        @(posedge clk); #1;
        n_vec++;
        if (regWrite !== 1'b1 || rd !== 5'd3 || writeData !== 64'hA || conflict_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL first_out0: got rw=%b rd=%0d wd=%h cnt=%0d want 1 3 a 1", regWrite, rd, writeData, conflict_cnt);
        end
        @(negedge clk);
        drive(0, 0, 0, 1, 4, 64'hB);
        #1;
        n_vec++;
        if ({a_ready, b_ready} !== 2'b01) begin
            n_err++; $display("FAIL first_ready1: got %b want 01", {a_ready, b_ready});
        end
        @(posedge clk); #1;
        n_vec++;
        if (regWrite !== 1'b1 || rd !== 5'd4 || writeData !== 64'hB || conflict_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL first_out1: got rw=%b rd=%0d wd=%h cnt=%0d want 1 4 b 1", regWrite, rd, writeData, conflict_cnt);
        end
    endtask

    task automatic test_sustained();
        int ka = 0;
        int kb = 0;
        for (int i = 0; i < 6; i++) begin
            logic        exp_a;
            logic [4:0]  exp_rd;
            logic [63:0] exp_wd;
            exp_a = (i % 2 == 0);
            @(negedge clk);
            drive(1, 5'(1 + ka), 64'(8'hA0 + ka), 1, 5'(10 + kb), 64'(8'hB0 + kb));
            exp_rd = exp_a ? 5'(1 + ka) : 5'(10 + kb);
            exp_wd = exp_a ? 64'(8'hA0 + ka) : 64'(8'hB0 + kb);
            #1;
            n_vec++;
            if ({a_ready, b_ready} !== {exp_a, ~exp_a}) begin
                n_err++; $display("FAIL sustained_ready[%0d]: got %b want %b", i, {a_ready, b_ready}, {exp_a, ~exp_a});
            end
            @(posedge clk); #1;
            n_vec++;
            if (regWrite !== 1'b1 || rd !== exp_rd || writeData !== exp_wd || conflict_cnt !== 16'(i + 2)) begin
                n_err++;
                $display("FAIL sustained_out[%0d]: got rw=%b rd=%0d wd=%h cnt=%0d want 1 %0d %h %0d",
                         i, regWrite, rd, writeData, conflict_cnt, exp_rd, exp_wd, i + 2);
            end
            if (exp_a) ka++; else kb++;
        end
    endtask

    task automatic test_drops();
        @(negedge clk);
        drive(1, 0, 64'h55, 1, 7, 64'h77);
        #1;
        n_vec++;
        if ({a_ready, b_ready} !== 2'b11) begin
            n_err++; $display("FAIL drop_x0_ready: got %b want 11", {a_ready, b_ready});
        end
        @(posedge clk); #1;
        n_vec++;
        if (regWrite !== 1'b1 || rd !== 5'd7 || writeData !== 64'h77 || drop_err !== 1'b0 || conflict_cnt !== 16'd7) begin
            n_err++;
            $display("FAIL drop_x0_out: got rw=%b rd=%0d wd=%h de=%b cnt=%0d want 1 7 77 0 7",
                     regWrite, rd, writeData, drop_err, conflict_cnt);
        end
        @(negedge clk);
        drive(1, 20, 64'h99, 0, 0, 0);
        #1;
        n_vec++;
        if ({a_ready, b_ready} !== 2'b10) begin
            n_err++; $display("FAIL drop_oor_ready: got %b want 10", {a_ready, b_ready});
        end
        @(posedge clk); #1;
        n_vec++;
        if (regWrite !== 1'b0 || drop_err !== 1'b1 || rd !== 5'd7) begin
            n_err++; $display("FAIL drop_oor_out: got rw=%b de=%b rd=%0d want 0 1 7", regWrite, drop_err, rd);
        end
        @(negedge clk);
        drive(1, 18, 64'h18, 1, 17, 64'h1717);
        #1;
        n_vec++;
        if ({a_ready, b_ready} !== 2'b11) begin
            n_err++; $display("FAIL drop_edge_ready: got %b want 11", {a_ready, b_ready});
        end
        @(posedge clk); #1;
        n_vec++;
        if (regWrite !== 1'b1 || rd !== 5'd17 || writeData !== 64'h1717 || drop_err !== 1'b1) begin
            n_err++;
            $display("FAIL drop_edge_out: got rw=%b rd=%0d wd=%h de=%b want 1 17 1717 1", regWrite, rd, writeData, drop_err);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        n_vec++;
        if (drop_err !== 1'b0 || regWrite !== 1'b0) begin
            n_err++; $display("FAIL drop_clear: got de=%b rw=%b want 0 0", drop_err, regWrite);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        drive(1, 1, 64'h01, 0, 0, 0);
        @(negedge clk);
        drive(1, 9, 64'h11, 1, 9, 64'h22);
        #1;
        n_vec++;
        if ({a_ready, b_ready} !== 2'b01) begin
            n_err++; $display("FAIL collide_ready0: got %b want 01", {a_ready, b_ready});
        end
        @(posedge clk); #1;
        n_vec++;
        if (regWrite !== 1'b1 || rd !== 5'd9 || writeData !== 64'h22 || conflict_cnt !== 16'd8) begin
            n_err++;
            $display("FAIL collide_out0: got rw=%b rd=%0d wd=%h cnt=%0d want 1 9 22 8", regWrite, rd, writeData, conflict_cnt);
        end
        @(negedge clk);
        drive(1, 9, 64'h11, 0, 0, 0);
        #1;
        n_vec++;
        if ({a_ready, b_ready} !== 2'b10) begin
            n_err++; $display("FAIL collide_ready1: got %b want 10", {a_ready, b_ready});
        end
        @(posedge clk); #1;
        n_vec++;
        if (regWrite !== 1'b1 || rd !== 5'd9 || writeData !== 64'h11) begin
            n_err++; $display("FAIL collide_out1: got rw=%b rd=%0d wd=%h want 1 9 11", regWrite, rd, writeData);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        n_vec++;
        if (shadow[9] !== 64'h11) begin
            n_err++; $display("FAIL collide_final: got r9=%h want 11", shadow[9]);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(1, 6, 64'h66, 0, 0, 0);
        @(posedge clk); #1;
        n_vec++;
        if (regWrite !== 1'b1 || rd !== 5'd6) begin
            n_err++; $display("FAIL areset_pre: got rw=%b rd=%0d want 1 6", regWrite, rd);
        end
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if ({regWrite, rd, writeData, conflict_cnt} !== '0 || {a_ready, b_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL areset_clear: got rw=%b rd=%0d wd=%h cnt=%0d rdy=%b want all 0",
                     regWrite, rd, writeData, conflict_cnt, {a_ready, b_ready});
        end
        @(negedge clk);
        reset = 1'b0;
        drive(1, 2, 64'h2, 1, 3, 64'h3);
        #1;
        n_vec++;
        if ({a_ready, b_ready} !== 2'b10) begin
            n_err++; $display("FAIL areset_regrant: got %b want 10", {a_ready, b_ready});
        end
        @(posedge clk); #1;
        n_vec++;
        if (regWrite !== 1'b1 || rd !== 5'd2 || conflict_cnt !== 16'd1) begin
            n_err++; $display("FAIL areset_out: got rw=%b rd=%0d cnt=%0d want 1 2 1", regWrite, rd, conflict_cnt);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) shadow[i] = '0;
        test_reset();
        test_single();
        test_first_contention();
        test_sustained();
        test_drops();
        test_collision();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
